reg_file_write_arbiter: RTL and testbench
=========================================

// Module: reg_file_write_arbiter
// PURPOSE
//  Shares the single write port of reg_file between NUM_REQ requesters.
//  Uses a round-robin, req/ack handshake. Write signals to reg_file are registered.
//  Sits between the requesting engines and reg_file; the reg_file read port is not touched.
//  Two-state FSM; at most one write every 2 clocks.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ADDR_W   3  reg_file address width (8 entries)
//  DATA_W   8  reg_file data width
// PORTS
//  clock          in   1                clock; all state updates on posedge
//  reset          in   1                synchronous, active-high
//  req            in   NUM_REQ          req[i]=1: requester i wants one write
//  req_addr       in   NUM_REQ*ADDR_W   slice i = target address of requester i
//  req_data       in   NUM_REQ*DATA_W   slice i = write data of requester i
//  ack            out  NUM_REQ          one-hot, 1-cycle pulse: write of i is being committed
//  write_enable   out  1                to reg_file
//  write_address  out  ADDR_W           to reg_file
//  write_data     out  DATA_W           to reg_file
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, ack=0, write_enable=0, write_address=0, write_data=0.
//  - IDLE: if any req, pick winner w.
//    - w = first i with req[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
//    - On the next edge: write_enable=1; write_address/write_data = slice w; ack=1<<w;
//      ptr=(w+1) mod NUM_REQ; state goes to WRITE.
//    - If no req, outputs stay 0.
//  - WRITE: lasts exactly 1 cycle. reg_file commits on the edge that ends it.
//    On that edge write_enable=0, ack=0, state returns to IDLE.
//  - Requester rules:
//    - Holds req/addr/data stable from assertion until it samples ack=1.
//    - On that same edge it may drop req, or present a new transaction.
//  - Latency: req sampled in IDLE on edge k -> ack/write_enable high in cycle k..k+1
//    -> data in reg_file after edge k+1.
//  - Every requester is served within NUM_REQ grants of asserting req.
//  - Reqs arriving while in WRITE are evaluated on the next IDLE edge.
//  - Simultaneous reqs: only the winner is acked; the others keep waiting.
//  - ptr wrap: ptr=NUM_REQ-1 and w=NUM_REQ-1 -> ptr=0.
//  - Reset while in WRITE: write_enable and ack drop on that edge; that write is not committed.
//  - write_enable and ack are never high outside WRITE. $onehot0(ack) always holds.
// CONFIGURATION
//  REG_ARB_LOCK_EN defined: adds input `lock` (NUM_REQ bits).
//    - If the winner has lock[w]=1 when acked, it becomes owner.
//    - ptr does not advance; in IDLE only the owner's req is considered.
//    - Ownership is released when the owner is in IDLE with lock[w]=0 or req[w]=0.
//    - Reset clears ownership.
//  REG_ARB_LOCK_EN undefined: no `lock` port; pure round-robin as above.
// STRUCTURE
//  - Shared package reg_arb_pkg:
//    - state typedef {IDLE, WRITE}
//    - default ADDR_W/DATA_W constants, shared with reg_file
//  - Sub-module rr_pick (comb): inputs req vector and ptr; outputs winner index and found flag.
//    Reused by future read-port arbitration.
//  - Top level holds the FSM, ptr and output registers.
// TESTING
//  Bench instantiates the arbiter plus reg_file. Clock period 4, reset held 2 cycles.
//  1. Single req[2], addr=5, data=8'hA5
//     -> ack=4'b0100 for one cycle, write_enable for one cycle; reg_file[5]=A5.
//  2. req=4'b1111 held, data=i*16, addr=i, each requester drops req after its ack
//     -> acks in order 0,1,2,3 every 2 cycles; readback gives 00,10,20,30.
//  3. req=4'b1001 with ptr=1; after 0 is served, 0 re-requests
//     -> grant order 3,0,3,0: no starvation.
//  4. Reset asserted in the WRITE cycle
//     -> write_enable=0 and ack=0 after that edge; target entry keeps its old value; ptr=0.
//  5. No req for 10 cycles -> write_enable=0 and ack=0 throughout; state stays IDLE.
//  6. REG_ARB_LOCK_EN: req 1 with lock[1]=1 for 3 writes while req[0]=1
//     -> acks 1,1,1, then 0 after lock drops.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and default sizes for the reg_file write-port arbiter.
// The default address/data widths match reg_file.
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int REG_ADDR_W  = 3;
  localparam int REG_DATA_W  = 8;
  localparam int REG_NUM_REQ = 4;

  // Round-robin successor of idx among n requesters.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// Kept separate so the read-port arbiter can reuse it.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               found
);

  // Scan offsets from far to near so the closest request to ptr is written last.
  always_comb begin
    winner = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(ptr) + off) % NUM_REQ) == j)) begin
          winner = PTR_W'(j);
        end
      end
    end
  end

  assign found = |req;

endmodule

// File: rtl/reg_file_write_arbiter.sv
// Round-robin req/ack arbiter for the reg_file write port, one write per 2 clocks.
// Optional requester locking is enabled by defining REG_ARB_LOCK_EN.
module reg_file_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = REG_NUM_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock,
`endif
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  write_enable,
  output logic [ADDR_W-1:0]     write_address,
  output logic [DATA_W-1:0]     write_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                write_enable_q, write_enable_d;
  logic [ADDR_W-1:0]   write_address_q, write_address_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;

  logic [NUM_REQ-1:0]  cand_req;
  logic [PTR_W-1:0]    win;
  logic                found;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef REG_ARB_LOCK_EN
  logic                owner_valid_q, owner_valid_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                owner_hold;

  // An owner keeps the port only while it still requests with lock set.
  assign owner_hold = owner_valid_q && lock[owner_q] && req[owner_q];
  assign cand_req   = owner_hold ? (ONE_HOT0 << owner_q) : req;
`else
  assign cand_req   = req;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (cand_req),
    .ptr    (ptr_q),
    .winner (win),
    .found  (found)
  );

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    ack_d           = '0;
    write_enable_d  = 1'b0;
    write_address_d = '0;
    write_data_d    = '0;
`ifdef REG_ARB_LOCK_EN
    owner_valid_d   = owner_valid_q;
    owner_d         = owner_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef REG_ARB_LOCK_EN
        if (!owner_hold) begin
          owner_valid_d = 1'b0;
        end
`endif
        if (found) begin
          state_d         = WRITE;
          write_enable_d  = 1'b1;
          ack_d           = ONE_HOT0 << win;
          write_address_d = addr_arr[win];
          write_data_d    = data_arr[win];
`ifdef REG_ARB_LOCK_EN
          // A locking winner freezes the pointer so it is re-served next.
          if (lock[win]) begin
            owner_valid_d = 1'b1;
            owner_d       = win;
          end else begin
            ptr_d = PTR_W'(next_index(int'(win), NUM_REQ));
          end
`else
          ptr_d = PTR_W'(next_index(int'(win), NUM_REQ));
`endif
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      ack_q           <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
`ifdef REG_ARB_LOCK_EN
      owner_valid_q   <= 1'b0;
      owner_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      ack_q           <= ack_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
`ifdef REG_ARB_LOCK_EN
      owner_valid_q   <= owner_valid_d;
      owner_q         <= owner_d;
`endif
    end
  end

  assign ack           = ack_q;
  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;

endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed bench for reg_file_write_arbiter with a bench-side reg_file and
// a round-robin reference model checked every cycle (lock test needs REG_ARB_LOCK_EN).
module tb_reg_file_write_arbiter;
  import reg_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #2 clock = ~clock;

  logic [N-1:0]    req      = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0]    lock     = '0;
`endif
  logic [N-1:0]    ack;
  logic            write_enable;
  logic [AW-1:0]   write_address;
  logic [DW-1:0]   write_data;

  reg_file_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
`ifdef REG_ARB_LOCK_EN
    .lock          (lock),
`endif
    .req_addr      (req_addr),
    .req_data      (req_data),
    .ack           (ack),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // reg_file stand-in: commits on the edge ending WRITE, never while reset is high.
  logic [DW-1:0] rf [8];
  always @(posedge clock) begin
    if (write_enable && !reset) rf[write_address] <= write_data;
  end

  // Requesters: per-requester transaction lists, advanced when ack is sampled.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          lk;
  } tx_t;
  tx_t txq [N][16];
  int  hd [N] = '{default: 0};
  int  tl [N] = '{default: 0};
  logic [N-1:0] ack_seen = '0;

  task automatic push(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    txq[i][tl[i]] = '{a: a, d: d, lk: lk};
    tl[i]++;
  endtask

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i] && hd[i] < tl[i]) hd[i]++;
      if (hd[i] < tl[i]) begin
        req[i]                = 1'b1;
        req_addr[i*AW +: AW]  = txq[i][hd[i]].a;
        req_data[i*DW +: DW]  = txq[i][hd[i]].d;
`ifdef REG_ARB_LOCK_EN
        lock[i]               = txq[i][hd[i]].lk;
`endif
      end else begin
        req[i]                = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_data[i*DW +: DW]  = '0;
`ifdef REG_ARB_LOCK_EN
        lock[i]               = 1'b0;
`endif
      end
    end
  end

  // Reference model: grant scan over integer indices, one write then one idle cycle.
  int            cyc     = 0;
  logic          m_busy  = 1'b0;
  int            m_ptr   = 0;
  logic          m_own_v = 1'b0;
  int            m_own   = 0;
  logic [N-1:0]  exp_ack = '0;
  logic          exp_we  = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  always @(posedge clock) begin : model
    logic [N-1:0] cand;
    int w;
    cyc <= cyc + 1;
    if (reset) begin
      m_busy <= 1'b0; m_ptr <= 0; m_own_v <= 1'b0; m_own <= 0;
      exp_ack <= '0; exp_we <= 1'b0; exp_addr <= '0; exp_data <= '0;
    end else if (m_busy) begin
      m_busy <= 1'b0;
      exp_ack <= '0; exp_we <= 1'b0; exp_addr <= '0; exp_data <= '0;
    end else begin
      cand = req;
`ifdef REG_ARB_LOCK_EN
      if (m_own_v && lock[m_own] && req[m_own]) begin
        cand = '0;
        cand[m_own] = 1'b1;
      end else begin
        m_own_v <= 1'b0;
      end
`endif
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && cand[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w < 0) begin
        exp_ack <= '0; exp_we <= 1'b0; exp_addr <= '0; exp_data <= '0;
      end else begin
        m_busy   <= 1'b1;
        exp_we   <= 1'b1;
        exp_ack  <= N'(1) << w;
        exp_addr <= req_addr[w*AW +: AW];
        exp_data <= req_data[w*DW +: DW];
`ifdef REG_ARB_LOCK_EN
        if (lock[w]) begin
          m_own_v <= 1'b1;
          m_own   <= w;
        end else begin
          m_ptr <= (w + 1) % N;
        end
`else
        m_ptr <= (w + 1) % N;
`endif
      end
    end
  end

  // Compare process and grant log, sampled on the falling edge.
  int glog [$];
  int gcyc [$];
  int ack_cycles = 0;

  always @(negedge clock) begin
    ack_seen = ack;
    if (cyc > 0) begin
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("write_enable", 32'(write_enable), 32'(exp_we));
      chk("write_address", 32'(write_address), 32'(exp_addr));
      chk("write_data", 32'(write_data), 32'(exp_data));
      chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    end
    if (ack != '0) ack_cycles++;
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        glog.push_back(i);
        gcyc.push_back(cyc);
        $display("txn t=%0t requester=%0d addr=%0d data=%02h", $time, i, write_address, write_data);
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (glog.size() < target && n < budget) begin
      step();
      n++;
    end
    if (glog.size() < target) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=%0d required=%0d", glog.size(), target);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  function automatic int glog_at(input int idx);
    return (idx < glog.size()) ? glog[idx] : -1;
  endfunction

  initial begin
    int base;
    int we_cnt;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_we", 32'(write_enable), 32'd0);
    chk("reset_addr", 32'(write_address), 32'd0);
    chk("reset_data", 32'(write_data), 32'd0);

    // 1: single request from requester 2
    base = glog.size();
    ack_cycles = 0;
    push(2, 3'd5, 8'hA5, 1'b0);
    wait_grants(base + 1, 20);
    chk("t1_ack_vec", 32'(ack), 32'h4);
    repeat (4) step();
    chk("t1_winner", 32'(glog_at(base)), 32'd2);
    chk("t1_ack_len", 32'(ack_cycles), 32'd1);
    chk("t1_rf5", 32'(rf[5]), 32'hA5);

    // 2: all four request together, served 0..3 two cycles apart
    do_reset();
    base = glog.size();
    for (int i = 0; i < N; i++) push(i, AW'(i), DW'(i * 16), 1'b0);
    wait_grants(base + 4, 60);
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      chk("t2_order", 32'(glog_at(base + i)), 32'(i));
      chk("t2_rf", 32'(rf[i]), 32'(i * 16));
    end
    for (int i = 1; i < N; i++)
      if (base + i < gcyc.size())
        chk("t2_spacing", 32'(gcyc[base + i] - gcyc[base + i - 1]), 32'd2);

    // 3: ptr=1 with requesters 0 and 3 alternating, no starvation
    do_reset();
    base = glog.size();
    push(0, 3'd7, 8'h70, 1'b0);
    wait_grants(base + 1, 20);
    push(0, 3'd6, 8'h61, 1'b0);
    push(0, 3'd6, 8'h62, 1'b0);
    push(3, 3'd4, 8'h31, 1'b0);
    push(3, 3'd4, 8'h32, 1'b0);
    wait_grants(base + 5, 60);
    chk("t3_g0", 32'(glog_at(base + 1)), 32'd3);
    chk("t3_g1", 32'(glog_at(base + 2)), 32'd0);
    chk("t3_g2", 32'(glog_at(base + 3)), 32'd3);
    chk("t3_g3", 32'(glog_at(base + 4)), 32'd0);
    repeat (3) step();
    chk("t3_rf6", 32'(rf[6]), 32'h62);
    chk("t3_rf4", 32'(rf[4]), 32'h32);

    // 4: reset during WRITE aborts the write and clears ptr
    do_reset();
    base = glog.size();
    push(1, 3'd1, 8'hEE, 1'b0);
    wait_grants(base + 1, 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_we", 32'(write_enable), 32'd0);
    chk("t4_ack", 32'(ack), 32'd0);
    step();
    chk("t4_rf1_kept", 32'(rf[1]), 32'h10);
    base = glog.size();
    push(1, 3'd2, 8'h44, 1'b0);
    push(2, 3'd3, 8'h55, 1'b0);
    wait_grants(base + 2, 40);
    chk("t4_ptr0_g0", 32'(glog_at(base)), 32'd1);
    chk("t4_ptr0_g1", 32'(glog_at(base + 1)), 32'd2);
    repeat (3) step();

    // 5: idle for 10 cycles
    we_cnt = 0;
    ack_cycles = 0;
    repeat (10) begin
      step();
      if (write_enable) we_cnt++;
    end
    chk("t5_we_cnt", 32'(we_cnt), 32'd0);
    chk("t5_ack_cnt", 32'(ack_cycles), 32'd0);

`ifdef REG_ARB_LOCK_EN
    // 6: requester 1 locks for three writes while requester 0 waits
    do_reset();
    base = glog.size();
    push(1, 3'd1, 8'hA1, 1'b1);
    push(1, 3'd2, 8'hA2, 1'b1);
    push(1, 3'd3, 8'hA3, 1'b1);
    wait_grants(base + 1, 20);
    push(0, 3'd0, 8'hB0, 1'b0);
    wait_grants(base + 4, 60);
    chk("t6_g0", 32'(glog_at(base)), 32'd1);
    chk("t6_g1", 32'(glog_at(base + 1)), 32'd1);
    chk("t6_g2", 32'(glog_at(base + 2)), 32'd1);
    chk("t6_g3", 32'(glog_at(base + 3)), 32'd0);
    repeat (3) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
